fifo_write_ctrl: RTL and testbench

//   Write-side pointer and flag controller of the asynchronous FIFO, clocked in the clk_out domain.

---
 rtl/fifo_write_ctrl.sv | 77 +++++++
 tb/tb_fifo_write_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller of the async FIFO (clk_out domain).
// Produces the RAM write strobe/address, the Gray write pointer, and full/level/overflow status.
module fifo_write_ctrl #(
  parameter int addrbits     = 8,
  parameter int AFULL_THRESH = 252
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                sync_flush,
  input  logic                wr_en,
  input  logic [addrbits:0]   sync_rdptr,
  output logic                wr_fire,
  output logic [addrbits-1:0] waddr,
  output logic [addrbits:0]   wrptr,
  output logic                full,
  output logic                almost_full,
  output logic [addrbits:0]   wr_level,
  output logic                overflow
);

  localparam int PW = addrbits + 1;
  localparam logic [addrbits:0] AF_LVL = PW'(AFULL_THRESH);

  logic [addrbits:0] wbin;
  logic [addrbits:0] wbin_next;
  logic [addrbits:0] wgray_next;
  logic [addrbits:0] rd_bin;
  logic [addrbits:0] level_next;
  logic              full_next;

  // Handshake: wr_en is the producer's valid, ~full is our ready; a write is
  // committed exactly on cycles where wr_fire is high, and never during a flush.
  assign wr_fire = wr_en & ~full & ~sync_flush;
  assign waddr   = wbin[addrbits-1:0];

  // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    rd_bin[addrbits] = sync_rdptr[addrbits];
    for (int i = addrbits - 1; i >= 0; i--) begin
      rd_bin[i] = rd_bin[i+1] ^ sync_rdptr[i];
    end
  end

  assign wbin_next  = wbin + {{addrbits{1'b0}}, wr_fire};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign level_next = wbin_next - rd_bin;
  // Full when the write pointer has lapped the read pointer by exactly one depth.
  assign full_next  = (wgray_next == {~sync_rdptr[addrbits:addrbits-1],
                                      sync_rdptr[addrbits-2:0]});

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      wbin        <= '0;
      wrptr       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else if (sync_flush) begin
      wbin        <= '0;
      wrptr       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wrptr       <= wgray_next;
      full        <= full_next;
      almost_full <= (level_next >= AF_LVL);
      wr_level    <= level_next;
      overflow    <= overflow | (wr_en & full);
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl at depth 4 (addrbits=2, AFULL_THRESH=3).
// An occupancy model (total writes minus total reads) is compared on every negedge.
module tb_fifo_write_ctrl;

  localparam int DEPTH = 4;

  logic       clk_out = 1'b0;
  logic       rst;
  logic       sync_flush;
  logic       wr_en;
  logic [2:0] sync_rdptr;
  logic       wr_fire;
  logic [1:0] waddr;
  logic [2:0] wrptr;
  logic       full;
  logic       almost_full;
  logic [2:0] wr_level;
  logic       overflow;

  int tests_run = 0;
  int failures  = 0;
  int rd_cnt    = 0;
  bit checking  = 1'b0;

  // model state: total writes accepted since last clear, plus registered flags
  int m_tot = 0;
  int m_lvl = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ovf  = 1'b0;

  logic [2:0] exp_q[$];

  function automatic logic [2:0] gray3(input int b);
    logic [2:0] v;
    v = b[2:0];
    return v ^ (v >> 1);
  endfunction

  assign sync_rdptr = gray3(rd_cnt);

  fifo_write_ctrl #(.addrbits(2), .AFULL_THRESH(3)) dut (
    .clk_out    (clk_out),
    .rst        (rst),
    .sync_flush (sync_flush),
    .wr_en      (wr_en),
    .sync_rdptr (sync_rdptr),
    .wr_fire    (wr_fire),
    .waddr      (waddr),
    .wrptr      (wrptr),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .overflow   (overflow)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // occupancy model: level is simply writes minus reads
  always @(posedge clk_out or negedge rst) begin
    if (!rst || sync_flush) begin
      m_tot  = 0;
      m_lvl  = 0;
      m_full = 1'b0;
      m_af   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_ovf  = m_ovf || (wr_en && m_full);
      if (wr_en && !m_full) m_tot = m_tot + 1;
      m_lvl  = m_tot - rd_cnt;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= 3);
    end
  end

  always @(negedge clk_out) begin
    if (checking) begin
      chk("cyc_wr_fire", wr_fire, 32'(wr_en && !m_full && !sync_flush));
      chk("cyc_waddr", waddr, 32'(m_tot % DEPTH));
      chk("cyc_wrptr", wrptr, gray3(m_tot));
      chk("cyc_full", full, m_full);
      chk("cyc_almost_full", almost_full, m_af);
      chk("cyc_wr_level", wr_level, m_lvl);
      chk("cyc_overflow", overflow, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    sync_flush = 1'b0;
    wr_en = 1'b0;
    rd_cnt = 0;
    repeat (2) tick();
    chk("rst_wrptr", wrptr, 0);
    chk("rst_level", wr_level, 0);
    chk("rst_flags", {full, almost_full, overflow}, 0);
    rst = 1'b1;
    checking = 1'b1;
    tick();

    // fill: four writes against an idle reader
    exp_q = {3'b001, 3'b011, 3'b010, 3'b110};
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_waddr", waddr, i);
      chk("fill_fire", wr_fire, 1);
      tick();
      chk("fill_wrptr", wrptr, exp_q.pop_front());
      chk("fill_level", wr_level, i + 1);
      chk("fill_af", almost_full, (i >= 2) ? 1 : 0);
      chk("fill_full", full, (i == 3) ? 1 : 0);
    end

    // overflow: write attempt while full is dropped and latched
    #1;
    chk("ovf_fire", wr_fire, 0);
    tick();
    chk("ovf_wrptr", wrptr, 3'b110);
    chk("ovf_flag", overflow, 1);
    wr_en = 1'b0;
    tick();
    chk("ovf_sticky", overflow, 1);

    // drain then wrap the pointer through 7 -> 0
    rd_cnt = 4;
    tick();
    chk("drain_full", full, 0);
    chk("drain_level", wr_level, 0);
    wr_en = 1'b1;
    repeat (4) tick();
    wr_en = 1'b0;
    chk("wrap_wrptr", wrptr, 3'b000);
    chk("wrap_full", full, 1);
    chk("wrap_level", wr_level, 4);

    // flush with a pending write and overflow set
    rd_cnt = 6;
    tick();
    chk("pre_flush_level", wr_level, 2);
    chk("pre_flush_ovf", overflow, 1);
    wr_en = 1'b1;
    sync_flush = 1'b1;
    rd_cnt = 0;
    #1;
    chk("flush_fire", wr_fire, 0);
    tick();
    wr_en = 1'b0;
    sync_flush = 1'b0;
    chk("flush_wrptr", wrptr, 0);
    chk("flush_level", wr_level, 0);
    chk("flush_flags", {full, almost_full, overflow}, 0);

    // simultaneous write and read advance
    wr_en = 1'b1;
    repeat (3) tick();
    chk("sim_pre_level", wr_level, 3);
    rd_cnt = 1;
    tick();
    wr_en = 1'b0;
    chk("sim_level", wr_level, 3);
    chk("sim_full", full, 0);
    chk("sim_wrptr", wrptr, 3'b110);

    // asynchronous reset in the middle of a write
    wr_en = 1'b1;
    #2;
    rst = 1'b0;
    rd_cnt = 0;
    #1;
    chk("arst_wrptr", wrptr, 0);
    chk("arst_level", wr_level, 0);
    chk("arst_flags", {full, almost_full, overflow}, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_fire_follows", wr_fire, 1);
    tick();
    wr_en = 1'b0;
    chk("arst_first_wrptr", wrptr, 3'b001);
    tick();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
